// File: rtl/iadc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iadc_pkg
// Description : Shared widths, types and bit-growth helpers for the
//               sigma-delta / CIC decimation chain.
// Revision    : 1.0 - initial release
// ============================================================================
package iadc_pkg;

   localparam int c_in_w        = 9;
   localparam int c_out_w       = 18;
   localparam int c_cic_order   = 2;
   localparam int c_decim_ratio = 16;

   typedef logic [c_in_w-1:0]  sample_t;
   typedef logic [c_out_w-1:0] acc_t;

   // Minimum register width needed to hold the chain's growth without loss.
   function automatic int cic_min_width(input int in_w);
      return in_w + c_cic_order * $clog2(c_decim_ratio);
   endfunction

endpackage : iadc_pkg
`default_nettype wire

// File: rtl/integrator_2.sv
`default_nettype none
// ============================================================================
// Module      : integrator_2
// Description : Unsigned running-sum integrator stage; wraps modulo 2^OUT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module integrator_2
   import iadc_pkg::*;
#(
   parameter int IN_W  = c_in_w,
   parameter int OUT_W = c_out_w
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  data_in,
   output logic [OUT_W-1:0] data_out
);

   generate
      if (OUT_W < IN_W) begin : g_chk_in_width
         $error("integrator_2: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
      end
      if (OUT_W < cic_min_width(IN_W)) begin : g_chk_growth
         $error("integrator_2: OUT_W (%0d) too narrow for chain bit growth (%0d)",
                OUT_W, cic_min_width(IN_W));
      end
   endgenerate

   logic [OUT_W-1:0] r_acc;
   logic [OUT_W-1:0] w_sum;

   // Zero-extend the sample; the carry out of the top bit is dropped on purpose.
   assign w_sum = r_acc + OUT_W'(data_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else begin
         r_acc <= w_sum;
      end
   end

   assign data_out = r_acc;

`ifndef SYNTHESIS
   // Cleared by any reset pulse, so the step check skips edges that follow one.
   logic r_live;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

   a_reset_zero : assert property (@(posedge clk) !rst_n |-> (data_out == '0))
      else $error("integrator_2: data_out nonzero during reset");

   a_accumulate : assert property (@(posedge clk)
      r_live |-> (data_out == OUT_W'($past(data_out) + OUT_W'($past(data_in)))))
      else $error("integrator_2: accumulate step incorrect");
`endif

endmodule : integrator_2
`default_nettype wire

// File: tb/tb_integrator_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_integrator_2
// Description : Directed and random self-checking bench for integrator_2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_integrator_2;
   import iadc_pkg::*;

   logic    clk;
   logic    rst_n;
   sample_t data_in;
   acc_t    data_out;

   int errors;
   int checks;

   logic [8:0]  ramp_in  [12] = '{9'd1, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5,
                                  9'd6, 9'd6, 9'd6, 9'd6, 9'd7, 9'd8};
   logic [17:0] ramp_exp [12] = '{18'd1, 18'd2, 18'd4, 18'd7, 18'd11, 18'd16,
                                  18'd22, 18'd28, 18'd34, 18'd40, 18'd47, 18'd55};

   integrator_2 #(
      .IN_W  (9),
      .OUT_W (18)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive a sample, let one rising edge take it, settle just past the edge.
   task automatic step(input logic [8:0] v);
      data_in = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [17:0] model;
      logic [8:0]  v;
      errors  = 0;
      checks  = 0;
      rst_n   = 1'b0;
      data_in = 9'd5;

      // Reset held across edges with a nonzero sample
      repeat (2) begin
         @(posedge clk);
         #1;
         check("rst_hold", data_out, 18'd0);
      end
      rst_n = 1'b1;
      step(9'd5);
      check("rst_release", data_out, 18'd5);

      // Asynchronous clear, no clock edge involved
      rst_n = 1'b0;
      #1;
      check("rst_async", data_out, 18'd0);
      rst_n = 1'b1;

      // Ramp then hold
      for (int i = 0; i < 12; i++) begin
         step(ramp_in[i]);
         check("ramp", data_out, ramp_exp[i]);
      end
      for (int i = 0; i < 4; i++) begin
         step(9'd0);
         check("hold", data_out, 18'd55);
      end

      // Reset pulse between edges mid-run
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step(ramp_in[i]);
      check("mid_pre", data_out, 18'd40);
      rst_n = 1'b0;
      #2;
      check("mid_rst", data_out, 18'd0);
      rst_n = 1'b1;
      step(9'd7);
      check("mid_restart", data_out, 18'd7);
      step(9'd2);
      check("mid_accum", data_out, 18'd9);

      // Wrap at 2^18
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      repeat (513) step(9'd511);
      check("wrap_full", data_out, 18'd262143);
      step(9'd1);
      check("wrap_zero", data_out, 18'd0);
      step(9'd3);
      check("wrap_after", data_out, 18'd3);

      // Random against a modulo-2^18 reference
      model = 18'd3;
      for (int i = 0; i < 10000; i++) begin
         v = 9'($urandom_range(0, 511));
         step(v);
         model = model + {9'd0, v};
         check("random", data_out, model);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_integrator_2
`default_nettype wire
